// File: rtl/dice_seg_display_pkg.sv
// Shared types and segment tables for the dice result display.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package dice_disp_pkg;

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        ROLL  = 2'd1,
        BLINK = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Spinning single segment a..f used while a roll is in progress.
    localparam int         ANIM_STEPS = 6;
    localparam logic [6:0] SEG_ANIM [0:ANIM_STEPS-1] = '{
        7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20
    };

endpackage

// File: rtl/dice_seg_display_if.sv
// Roller-to-display signal bundle: BCD pair and roll flag in, segment drive out.
interface dice_seg_display_if;
    logic [3:0] digit10_in;
    logic [3:0] digit1_in;
    logic       rolling;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic       settled;

    modport master (
        output digit10_in, digit1_in, rolling,
        input  seg, dig_sel, settled
    );

    modport slave (
        input  digit10_in, digit1_in, rolling,
        output seg, dig_sel, settled
    );
endinterface

// File: rtl/dice_seg_display_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg
    import dice_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
    end
endmodule

// File: rtl/dice_seg_display.sv
// Two-digit multiplexed 7-segment driver for the dice roller result.
// Optional settle blink after a roll is compiled in with SETTLE_BLINK_EN.
//   state | meaning
//   SHOW  | frozen snapshot shown steadily, settled=1
//   ROLL  | button held, spinning-segment animation
//   BLINK | snapshot blinks 4 on/4 off phases before SHOW (SETTLE_BLINK_EN only)
module dice_seg_display
    import dice_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 64,
    parameter int ANIM_DIV    = 2048,
    parameter int BLINK_DIV   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    dice_seg_display_if.slave bus
);
    localparam int RW   = $clog2(REFRESH_DIV);
    // One timer width serves both the animation and blink down-counters.
    localparam int TMAX = (ANIM_DIV > BLINK_DIV) ? ANIM_DIV : BLINK_DIV;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] ANIM_LOAD = TW'(ANIM_DIV - 1);
`ifdef SETTLE_BLINK_EN
    localparam logic [TW-1:0] BLINK_LOAD    = TW'(BLINK_DIV - 1);
    localparam disp_state_t   CAPTURE_STATE = BLINK;
`else
    localparam disp_state_t   CAPTURE_STATE = SHOW;
`endif

    disp_state_t   state, state_d;
    logic          roll_q, capture, digit_q;
    logic [3:0]    snap10, snap1, digit_val;
    logic [RW-1:0] ref_cnt;
    logic [TW-1:0] anim_cnt;
    logic [2:0]    anim_idx;
    logic [6:0]    dec_seg, show_seg, seg_d, seg_q;
    logic [1:0]    slot_sel, show_dig, dig_d, dig_q;
    logic          settled_d, settled_q;
`ifdef SETTLE_BLINK_EN
    logic [TW-1:0] blink_cnt;
    logic [2:0]    blink_phase;
    logic          blink_done;

    assign blink_done = (blink_cnt == '0) && (blink_phase == 3'd7);
`endif

    assign capture   = roll_q & ~bus.rolling;
    assign digit_val = digit_q ? snap10 : snap1;

    bcd_to_seg u_dec (
        .bcd (digit_val),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= SHOW;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            SHOW:    if (bus.rolling) state_d = ROLL;
            ROLL:    if (capture) state_d = CAPTURE_STATE;
`ifdef SETTLE_BLINK_EN
            BLINK: begin
                if (bus.rolling)     state_d = ROLL;
                else if (blink_done) state_d = SHOW;
            end
`endif
            default: state_d = SHOW;
        endcase
    end

    always_comb begin
        slot_sel = digit_q ? 2'b10 : 2'b01;
        show_seg = dec_seg;
        show_dig = slot_sel;
        // Leading zero suppressed, but "00" (a roll of 100) stays lit.
        if (digit_q && snap10 == 4'd0 && snap1 != 4'd0) begin
            show_seg = SEG_BLANK;
            show_dig = 2'b00;
        end
        seg_d     = SEG_BLANK;
        dig_d     = 2'b00;
        settled_d = 1'b0;
        case (state)
            SHOW: begin
                seg_d     = show_seg;
                dig_d     = show_dig;
                settled_d = 1'b1;
            end
            ROLL: begin
                seg_d = SEG_ANIM[anim_idx];
                dig_d = slot_sel;
            end
`ifdef SETTLE_BLINK_EN
            BLINK: begin
                if (!blink_phase[0]) begin
                    seg_d = show_seg;
                    dig_d = show_dig;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            roll_q   <= 1'b0;
            snap10   <= 4'd0;
            snap1    <= 4'd1;
            ref_cnt  <= '0;
            digit_q  <= 1'b0;
            anim_cnt <= '0;
            anim_idx <= '0;
        end else begin
            roll_q <= bus.rolling;
            if (capture) begin
                snap10 <= bus.digit10_in;
                snap1  <= bus.digit1_in;
            end
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                digit_q <= ~digit_q;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            if (state_d == ROLL && state != ROLL) begin
                anim_cnt <= ANIM_LOAD;
                anim_idx <= '0;
            end else if (state == ROLL) begin
                if (anim_cnt == '0) begin
                    anim_cnt <= ANIM_LOAD;
                    anim_idx <= (anim_idx == 3'(ANIM_STEPS - 1)) ? 3'd0 : anim_idx + 3'd1;
                end else begin
                    anim_cnt <= anim_cnt - 1'b1;
                end
            end
        end
    end

`ifdef SETTLE_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= '0;
        end else if (state_d == BLINK && state != BLINK) begin
            blink_cnt   <= BLINK_LOAD;
            blink_phase <= '0;
        end else if (state == BLINK) begin
            if (blink_cnt == '0) begin
                blink_cnt   <= BLINK_LOAD;
                blink_phase <= blink_phase + 3'd1;
            end else begin
                blink_cnt <= blink_cnt - 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= SEG_BLANK;
            dig_q     <= 2'b00;
            settled_q <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            settled_q <= settled_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_q;
    assign bus.settled = settled_q;
endmodule

// File: tb/tb_dice_seg_display.sv
// Self-checking bench for dice_seg_display against a time-based behavioural model.
module tb_dice_seg_display;
    localparam int RD = 4;
    localparam int AD = 8;
    localparam int BD = 16;
    localparam int M_SHOW  = 0;
    localparam int M_ROLL  = 1;
    localparam int M_BLINK = 2;
`ifdef SETTLE_BLINK_EN
    localparam int M_AFTER = M_BLINK;
`else
    localparam int M_AFTER = M_SHOW;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dice_seg_display_if bus ();

    dice_seg_display #(
        .REFRESH_DIV (RD),
        .ANIM_DIV    (AD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: mode plus elapsed edges; slot and animation follow from time alone.
    int m_t, m_enter, m_mode, m_s10, m_s1;
    bit m_prev_roll;
    logic [6:0] exp_seg;
    logic [1:0] exp_dig;
    logic       exp_set;

    function automatic logic [6:0] digit_pattern(int v);
        case (v)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic model_reset();
        m_t = 0; m_enter = 0; m_mode = M_SHOW;
        m_s10 = 0; m_s1 = 1; m_prev_roll = 1'b0;
        exp_seg = 7'h00; exp_dig = 2'b00; exp_set = 1'b0;
    endtask

    task automatic model_predict();
        int tens, el;
        tens = (m_t / RD) % 2;
        el   = m_t - m_enter;
        exp_seg = 7'h00;
        exp_dig = 2'b00;
        exp_set = (m_mode == M_SHOW);
        if (m_mode == M_ROLL) begin
            exp_seg = 7'(1 << ((el / AD) % 6));
            exp_dig = tens ? 2'b10 : 2'b01;
        end else if (m_mode == M_SHOW || ((el / BD) % 2) == 0) begin
            if (!(tens == 1 && m_s10 == 0 && m_s1 != 0)) begin
                exp_seg = digit_pattern(tens ? m_s10 : m_s1);
                exp_dig = tens ? 2'b10 : 2'b01;
            end
        end
    endtask

    task automatic model_advance(bit r, int d10, int d1);
        bit cap;
        int nxt;
        cap = m_prev_roll && !r;
        nxt = m_mode;
        if (cap) begin m_s10 = d10; m_s1 = d1; end
        if (m_mode == M_SHOW && r) nxt = M_ROLL;
        else if (m_mode == M_ROLL && cap) nxt = M_AFTER;
        else if (m_mode == M_BLINK) begin
            if (r) nxt = M_ROLL;
            else if (m_t - m_enter == 8 * BD - 1) nxt = M_SHOW;
        end
        m_t++;
        if (nxt != m_mode) begin m_mode = nxt; m_enter = m_t; end
        m_prev_roll = r;
    endtask

    task automatic step(string tag, bit r, logic [3:0] d10, logic [3:0] d1);
        bus.rolling    = r;
        bus.digit10_in = d10;
        bus.digit1_in  = d1;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_predict();
            model_advance(r, int'(d10), int'(d1));
        end
        #1;
        checks++;
        assert (bus.seg === exp_seg) else begin
            failures++;
            $error("FAIL %s seg got=%h exp=%h t=%0d", tag, bus.seg, exp_seg, m_t);
        end
        checks++;
        assert (bus.dig_sel === exp_dig) else begin
            failures++;
            $error("FAIL %s dig_sel got=%b exp=%b t=%0d", tag, bus.dig_sel, exp_dig, m_t);
        end
        checks++;
        assert (bus.settled === exp_set) else begin
            failures++;
            $error("FAIL %s settled got=%b exp=%b t=%0d", tag, bus.settled, exp_set, m_t);
        end
    endtask

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    bit lvl;

    initial begin
        bus.rolling = 1'b0; bus.digit10_in = 4'd0; bus.digit1_in = 4'd0;
        model_reset();

        rst = 1'b1;
        step("reset", 1'b0, 4'd0, 4'd0);
        step("reset", 1'b1, 4'd3, 4'd3);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step("idle01", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 20; i++) step("roll20", 1'b1, rnd4(), rnd4());
        step("cap17", 1'b0, 4'd1, 4'd7);
        for (int i = 0; i < 16; i++) step("show17", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 5; i++) step("roll", 1'b1, rnd4(), rnd4());
        step("cap00", 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) step("show00", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 5; i++) step("roll", 1'b1, rnd4(), rnd4());
        step("cap05", 1'b0, 4'd0, 4'd5);
        for (int i = 0; i < 16; i++) step("show05", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 3; i++) step("roll", 1'b1, rnd4(), rnd4());
        step("capdash", 1'b0, 4'd3, 4'hC);
        for (int i = 0; i < 16; i++) step("showdash", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 10; i++) step("roll", 1'b1, rnd4(), rnd4());
        step("cap20", 1'b0, 4'd2, 4'd0);
        for (int i = 0; i < 140; i++) step("settle20", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 4; i++) step("roll", 1'b1, rnd4(), rnd4());
        step("cap", 1'b0, 4'd4, 4'd8);
        for (int i = 0; i < 40; i++) step("midblink", 1'b0, rnd4(), rnd4());
        for (int i = 0; i < 9; i++) step("reroll", 1'b1, rnd4(), rnd4());
        step("cap", 1'b0, 4'd9, 4'd9);
        for (int i = 0; i < 20; i++) step("show99", 1'b0, rnd4(), rnd4());

        for (int i = 0; i < 13; i++) step("rollrst", 1'b1, rnd4(), rnd4());
        rst = 1'b1;
        step("rstroll", 1'b1, rnd4(), rnd4());
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step("afterrst", 1'b0, rnd4(), rnd4());

        step("pulse", 1'b1, 4'd7, 4'd7);
        step("pulsecap", 1'b0, 4'd4, 4'd2);
        for (int i = 0; i < 140; i++) step("show42", 1'b0, rnd4(), rnd4());

        lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) lvl = ~lvl;
            step("random", lvl, rnd4(), rnd4());
        end
        for (int i = 0; i < 140; i++) step("drain", 1'b0, rnd4(), rnd4());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
